// File: rtl/psum_readout.sv
// Partial-sum readout: captures psum vectors into a small vector FIFO and
// streams them out one column word per beat over a valid/ready interface.
module psum_readout #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [bw_psum*col-1:0]    psum_in,
  input  logic                      psum_valid,
  output logic [bw_psum-1:0]        o_data,
  output logic [$clog2(col)-1:0]    o_col,
  output logic                      o_last,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int CW = $clog2(col);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = bw_psum*col;
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_COL = CW'(col-1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nx;
  logic [DEPTH-1:0][VW-1:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [VW-1:0]          head, sr;
  logic                   push, drop, pop, advance, go_idle;
  logic                   hs, last_hs, not_empty;

  // Full is judged on the registered count, so a same-cycle pop never rescues a strobe.
  assign not_empty = (fifo_count != '0);
  assign push      = psum_valid && (fifo_count != FULL);
  assign drop      = psum_valid && (fifo_count == FULL);
  assign head      = mem[rd_ptr];
  assign hs        = o_valid && o_ready;
  assign last_hs   = hs && (o_col == LAST_COL);
  assign o_last    = o_valid && (o_col == LAST_COL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    advance  = 1'b0;
    go_idle  = 1'b0;
    case (state)
      IDLE: if (not_empty) begin
        pop      = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        if (last_hs) begin
          // Back-to-back vectors chain without a bubble.
          if (not_empty) pop = 1'b1;
          else begin
            go_idle  = 1'b1;
            state_nx = IDLE;
          end
        end else if (hs) begin
          advance = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= psum_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_col      <= '0;
      sr         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) overflow <= 1'b1;
      if (pop) begin
        o_data  <= head[bw_psum-1:0];
        sr      <= head >> bw_psum;
        o_col   <= '0;
        o_valid <= 1'b1;
      end else if (advance) begin
        o_data  <= sr[bw_psum-1:0];
        sr      <= sr >> bw_psum;
        o_col   <= o_col + CW'(1);
      end else if (go_idle) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
